// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC constants, arbiter state encoding and flit layout helper
package noc_pkg;

    localparam int NORTH     = 0;
    localparam int SOUTH     = 1;
    localparam int EAST      = 2;
    localparam int WEST      = 3;
    localparam int LOCAL     = 4;
    localparam int NUM_PORTS = 5;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Flits are packed {dest_y, dest_x, data}, so data sits in the low bits.
    function automatic int flit_width(input int data_width, input int coord_bits);
        return data_width + 2 * coord_bits;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wraparound
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index
);

    // Walk from the farthest candidate to the nearest so the nearest requester wins.
    always_comb begin
        grant = '0;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                grant = '0;
                grant[(int'(ptr) + i) % N] = 1'b1;
                index = IW'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/noc_inject_arbiter.sv
// noc_inject_arbiter: packet-locked round-robin sharing of a router local injection port
module noc_inject_arbiter
    import noc_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 256,
    parameter int COORD_BITS    = 4,
    parameter int MAX_PKT_FLITS = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*COORD_BITS-1:0] req_dest_x,
    input  logic [NUM_REQ*COORD_BITS-1:0] req_dest_y,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [COORD_BITS-1:0]         out_dest_x,
    output logic [COORD_BITS-1:0]         out_dest_y,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic                          len_err,
    output logic [15:0]                   pkt_count
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int FW = flit_width(DATA_WIDTH, COORD_BITS);
    localparam int CW = $clog2(MAX_PKT_FLITS) + 1;

    arb_state_e            state_q;
    logic [FW-1:0]         flit_q, flit_d;
    logic [2*COORD_BITS-1:0] dest_q;
    logic [IW-1:0]         owner_q, rr_ptr_q, win, sel, rr_d;
    logic [CW-1:0]         flit_cnt_q, cnt_d;
    logic [15:0]           pkt_count_q;
    logic                  out_valid_q, len_err_q;
    logic [NUM_REQ-1:0]    grant;
    logic                  locked, load_ok, accept, pkt_end;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [COORD_BITS-1:0] sel_x, sel_y;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .index (win)
    );

    assign locked   = state_q == ARB_LOCKED;
    assign load_ok  = !out_valid_q || out_ready;
    assign sel      = locked ? owner_q : win;
    assign accept   = load_ok && req_valid[sel];
    assign sel_data = req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_x    = req_dest_x[int'(sel)*COORD_BITS +: COORD_BITS];
    assign sel_y    = req_dest_y[int'(sel)*COORD_BITS +: COORD_BITS];
    // Body flits reuse the destination captured from the head flit.
    assign flit_d   = locked ? {dest_q, sel_data} : {sel_y, sel_x, sel_data};
    assign cnt_d    = locked ? flit_cnt_q + 1'b1 : CW'(1);
    assign pkt_end  = accept && (req_last[sel] || cnt_d == CW'(MAX_PKT_FLITS));
    assign rr_d     = (sel == IW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
    assign req_ready = (rst_n && load_ok) ? (locked ? NUM_REQ'(1) << owner_q : grant) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            flit_q      <= '0;
            dest_q      <= '0;
            out_valid_q <= 1'b0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            flit_cnt_q  <= '0;
            pkt_count_q <= '0;
            len_err_q   <= 1'b0;
        end else begin
            len_err_q <= 1'b0;
            if (accept) begin
                flit_q      <= flit_d;
                out_valid_q <= 1'b1;
                flit_cnt_q  <= cnt_d;
                owner_q     <= sel;
                state_q     <= pkt_end ? ARB_IDLE : ARB_LOCKED;
                if (!locked) dest_q <= {sel_y, sel_x};
                if (pkt_end) begin
                    rr_ptr_q    <= rr_d;
                    pkt_count_q <= pkt_count_q + 16'd1;
                    len_err_q   <= !req_last[sel];
                end
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_data   = flit_q[DATA_WIDTH-1:0];
    assign out_dest_x = flit_q[DATA_WIDTH +: COORD_BITS];
    assign out_dest_y = flit_q[DATA_WIDTH+COORD_BITS +: COORD_BITS];
    assign out_valid  = out_valid_q;
    assign busy       = locked;
    assign owner      = owner_q;
    assign len_err    = len_err_q;
    assign pkt_count  = pkt_count_q;

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// tb_noc_inject_arbiter: directed scenario tests for the packet-locked injection arbiter
module tb_noc_inject_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int CB = 4;

    logic             clk, rst_n, out_ready, out_valid, busy, len_err;
    logic [NR*DW-1:0] req_data;
    logic [NR*CB-1:0] req_dest_x, req_dest_y;
    logic [NR-1:0]    req_last, req_valid, req_ready;
    logic [DW-1:0]    out_data;
    logic [CB-1:0]    out_dest_x, out_dest_y;
    logic [1:0]       owner;
    logic [15:0]      pkt_count;
    int n_cmp = 0;
    int n_bad = 0;

    noc_inject_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .COORD_BITS(CB), .MAX_PKT_FLITS(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_data(req_data), .req_dest_x(req_dest_x),
        .req_dest_y(req_dest_y), .req_last(req_last), .req_valid(req_valid),
        .req_ready(req_ready), .out_data(out_data), .out_dest_x(out_dest_x),
        .out_dest_y(out_dest_y), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .owner(owner), .len_err(len_err), .pkt_count(pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int r, input logic [DW-1:0] d, input logic [CB-1:0] x,
                         input logic [CB-1:0] y, input logic l, input logic v);
        req_data[r*DW +: DW]   = d;
        req_dest_x[r*CB +: CB] = x;
        req_dest_y[r*CB +: CB] = y;
        req_last[r]            = l;
        req_valid[r]           = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_data = '0; req_dest_x = '0; req_dest_y = '0; req_last = '0; req_valid = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        req_valid = 4'b1111;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", out_valid); end
        n_cmp++; if ({out_data, out_dest_x, out_dest_y} !== 24'h0) begin n_bad++; $display("FAIL rst_data got %h want 0", {out_data, out_dest_x, out_dest_y}); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_ready got %b want 0000", req_ready); end
        n_cmp++; if ({busy, owner, len_err} !== 4'b0) begin n_bad++; $display("FAIL rst_ctrl got %b want 0000", {busy, owner, len_err}); end
        n_cmp++; if (pkt_count !== 16'd0) begin n_bad++; $display("FAIL rst_count got %0d want 0", pkt_count); end
        req_valid = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        drive(0, 16'hA001, 4'd2, 4'd1, 1'b0, 1'b1); #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready got %b want 0001", req_ready); end
        tick();
        n_cmp++; if ({out_valid, out_data, out_dest_x, out_dest_y} !== 25'h1A00121) begin n_bad++; $display("FAIL single_f1 got %h want 1a00121", {out_valid, out_data, out_dest_x, out_dest_y}); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy1 got %b want 1", busy); end
        drive(0, 16'hA002, 4'd2, 4'd1, 1'b0, 1'b1);
        tick();
        n_cmp++; if ({out_valid, out_data} !== 17'h1A002) begin n_bad++; $display("FAIL single_f2 got %h want 1a002", {out_valid, out_data}); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy2 got %b want 1", busy); end
        drive(0, 16'hA003, 4'd2, 4'd1, 1'b1, 1'b1);
        tick();
        n_cmp++; if ({out_valid, out_data, out_dest_x, out_dest_y} !== 25'h1A00321) begin n_bad++; $display("FAIL single_f3 got %h want 1a00321", {out_valid, out_data, out_dest_x, out_dest_y}); end
        n_cmp++; if (busy !== 1'b0 || pkt_count !== 16'd1) begin n_bad++; $display("FAIL single_end busy %b count %0d want 0 1", busy, pkt_count); end
        drive(0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b0);
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_drain got %b want 0", out_valid); end
    endtask

    task automatic test_two_req();
        do_reset();
        drive(0, 16'hB000, 4'd1, 4'd1, 1'b0, 1'b1);
        drive(2, 16'hC000, 4'd3, 4'd3, 1'b0, 1'b1); #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL two_ready0 got %b want 0001", req_ready); end
        tick();
        n_cmp++; if (out_data !== 16'hB000 || owner !== 2'd0) begin n_bad++; $display("FAIL two_b0 got %h/%0d want b000/0", out_data, owner); end
        drive(0, 16'hB001, 4'd1, 4'd1, 1'b1, 1'b1); #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL two_lock got %b want 0001", req_ready); end
        tick();
        n_cmp++; if (out_data !== 16'hB001) begin n_bad++; $display("FAIL two_b1 got %h want b001", out_data); end
        drive(0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b0); #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL two_ready2 got %b want 0100", req_ready); end
        tick();
        n_cmp++; if ({out_data, out_dest_x, out_dest_y} !== 24'hC00033 || owner !== 2'd2) begin n_bad++; $display("FAIL two_c0 got %h/%0d want c00033/2", {out_data, out_dest_x, out_dest_y}, owner); end
        drive(2, 16'hC001, 4'd3, 4'd3, 1'b1, 1'b1);
        tick();
        n_cmp++; if (out_data !== 16'hC001 || pkt_count !== 16'd2 || owner !== 2'd2) begin n_bad++; $display("FAIL two_c1 got %h/%0d/%0d want c001/2/2", out_data, pkt_count, owner); end
        // rr_ptr should now be 3, so r3 beats r0
        drive(2, 16'h0, 4'd0, 4'd0, 1'b0, 1'b0);
        drive(0, 16'hB100, 4'd1, 4'd1, 1'b1, 1'b1);
        drive(3, 16'hD300, 4'd4, 4'd4, 1'b1, 1'b1); #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL two_ptr3 got %b want 1000", req_ready); end
        tick();
        n_cmp++; if (out_data !== 16'hD300 || owner !== 2'd3) begin n_bad++; $display("FAIL two_r3 got %h/%0d want d300/3", out_data, owner); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_stall();
        do_reset();
        drive(1, 16'hD000, 4'd4, 4'd2, 1'b0, 1'b1); #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL stall_ready0 got %b want 0010", req_ready); end
        tick();
        n_cmp++; if (out_data !== 16'hD000) begin n_bad++; $display("FAIL stall_d0 got %h want d000", out_data); end
        drive(1, 16'hD001, 4'd4, 4'd2, 1'b0, 1'b1);
        tick();
        n_cmp++; if (out_data !== 16'hD001) begin n_bad++; $display("FAIL stall_d1 got %h want d001", out_data); end
        drive(1, 16'hD002, 4'd4, 4'd2, 1'b0, 1'b1);
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL stall_ready%0d got %b want 0000", i, req_ready); end
            tick();
            n_cmp++; if ({out_valid, out_data, out_dest_x, out_dest_y} !== 25'h1D00142) begin n_bad++; $display("FAIL stall_hold%0d got %h want 1d00142", i, {out_valid, out_data, out_dest_x, out_dest_y}); end
        end
        out_ready = 1'b1; #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL stall_resume got %b want 0010", req_ready); end
        tick();
        n_cmp++; if (out_data !== 16'hD002) begin n_bad++; $display("FAIL stall_d2 got %h want d002", out_data); end
        drive(1, 16'hD003, 4'd4, 4'd2, 1'b1, 1'b1);
        tick();
        n_cmp++; if (out_data !== 16'hD003 || pkt_count !== 16'd1) begin n_bad++; $display("FAIL stall_d3 got %h/%0d want d003/1", out_data, pkt_count); end
        drive(1, 16'h0, 4'd0, 4'd0, 1'b0, 1'b0);
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_drain got %b want 0", out_valid); end
    endtask

    task automatic test_len_limit();
        logic [DW-1:0] exp_d;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            exp_d = 16'hE000 + DW'(i);
            drive(1, exp_d, 4'd1, 4'd1, i == 16, 1'b1); #1;
            n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL len_ready%0d got %b want 0010", i, req_ready); end
            tick();
            n_cmp++; if (out_data !== exp_d) begin n_bad++; $display("FAIL len_data%0d got %h want %h", i, out_data, exp_d); end
            n_cmp++; if (len_err !== (i == 15)) begin n_bad++; $display("FAIL len_err%0d got %b want %b", i, len_err, i == 15); end
        end
        n_cmp++; if (pkt_count !== 16'd2 || busy !== 1'b0 || owner !== 2'd1) begin n_bad++; $display("FAIL len_end got %0d/%b/%0d want 2/0/1", pkt_count, busy, owner); end
        drive(1, 16'h0, 4'd0, 4'd0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_dest_latch();
        do_reset();
        drive(2, 16'hF000, 4'd5, 4'd5, 1'b0, 1'b1);
        tick();
        n_cmp++; if ({out_dest_x, out_dest_y} !== 8'h55) begin n_bad++; $display("FAIL dest_head got %h want 55", {out_dest_x, out_dest_y}); end
        drive(2, 16'hF001, 4'd0, 4'd0, 1'b0, 1'b1);
        tick();
        n_cmp++; if ({out_data, out_dest_x, out_dest_y} !== 24'hF00155) begin n_bad++; $display("FAIL dest_body1 got %h want f00155", {out_data, out_dest_x, out_dest_y}); end
        drive(2, 16'hF002, 4'd0, 4'd0, 1'b1, 1'b1);
        tick();
        n_cmp++; if ({out_data, out_dest_x, out_dest_y} !== 24'hF00255) begin n_bad++; $display("FAIL dest_body2 got %h want f00255", {out_data, out_dest_x, out_dest_y}); end
        drive(2, 16'h0, 4'd0, 4'd0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1, 16'h6000, 4'd6, 4'd6, 1'b0, 1'b1);
        tick();
        drive(1, 16'h6001, 4'd6, 4'd6, 1'b0, 1'b1);
        tick();
        n_cmp++; if (out_data !== 16'h6001 || busy !== 1'b1 || owner !== 2'd1) begin n_bad++; $display("FAIL mid_pre got %h/%b/%0d want 6001/1/1", out_data, busy, owner); end
        drive(1, 16'h6002, 4'd6, 4'd6, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({out_valid, out_data, out_dest_x, out_dest_y} !== 25'h0) begin n_bad++; $display("FAIL mid_out got %h want 0", {out_valid, out_data, out_dest_x, out_dest_y}); end
        n_cmp++; if ({req_ready, busy, owner, len_err} !== 8'h0 || pkt_count !== 16'd0) begin n_bad++; $display("FAIL mid_ctrl got %b/%0d want 0/0", {req_ready, busy, owner, len_err}, pkt_count); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1, 16'h0, 4'd0, 4'd0, 1'b0, 1'b0);
        drive(3, 16'h7300, 4'd7, 4'd7, 1'b1, 1'b1); #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL mid_ready got %b want 1000", req_ready); end
        tick();
        n_cmp++; if ({out_data, out_dest_x, out_dest_y} !== 24'h730077 || owner !== 2'd3 || busy !== 1'b0) begin n_bad++; $display("FAIL mid_fresh got %h/%0d/%b want 730077/3/0", {out_data, out_dest_x, out_dest_y}, owner, busy); end
        req_valid = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_req();
        test_stall();
        test_len_limit();
        test_dest_latch();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/noc_inject_arbiter.md
# noc_inject_arbiter

Shares a router's single local injection port between NUM_REQ on-tile requesters (e.g. DMA read, DMA write, sync unit, host bridge). The block arbitrates at packet granularity and locks the port to one requester from its first flit until its last flit. It latches the packet's destination from the head flit and presents flits through one registered output stage that drives the router's local_in_* port. It sits inside the TPC, between the requesters and the mesh router.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- DATA_WIDTH, 256: flit payload width
- COORD_BITS, 4: X/Y coordinate width
- MAX_PKT_FLITS, 16: maximum flits per packet before forced release (power of 2, ≥2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_data  in  NUM_REQ*DATA_WIDTH  per-requester flit payload, requester r at slice r
- req_dest_x  in  NUM_REQ*COORD_BITS  per-requester destination X (sampled on head flit only)
- req_dest_y  in  NUM_REQ*COORD_BITS  per-requester destination Y (sampled on head flit only)
- req_last  in  NUM_REQ  flit is the final flit of its packet
- req_valid  in  NUM_REQ  flit valid
- req_ready  out  NUM_REQ  flit accepted when valid&ready
- out_data  out  DATA_WIDTH  to router local_in_data
- out_dest_x  out  COORD_BITS  to router local_in_dest_x
- out_dest_y  out  COORD_BITS  to router local_in_dest_y
- out_valid  out  1  to router local_in_valid
- out_ready  in  1  from router local_in_ready
- busy  out  1  a packet lock is held
- owner  out  $clog2(NUM_REQ)  index of current/last lock holder
- len_err  out  1  one-cycle pulse on forced release
- pkt_count  out  16  packets completed (wraps at 2^16)

## Operation
- States are IDLE and LOCKED.
- Output stage: out_valid/out_data/out_dest_* are registered. The stage can load when `load_ok = !out_valid || out_ready`.
- Arbitration in IDLE:
  - When load_ok, round-robin pick among req_valid, starting at rr_ptr.
  - The winner's req_ready is asserted combinationally in the same cycle, and its head flit loads the output stage.
  - req_dest_x/y of the winner are latched into dest_reg and also driven on out_dest_*.
  - owner <= winner.
  - flit_cnt <= 1.
  - If req_last is set on the head flit, the packet is complete immediately and the state stays IDLE; otherwise the state goes to LOCKED.
- LOCKED:
  - Only req_ready[owner] can assert, and it equals load_ok.
  - Each accepted flit uses dest_reg; the requester's dest inputs are ignored.
  - flit_cnt increments on each accepted flit.
  - If the owner drops valid, the lock is held and bubbles are inserted (out_valid falls once the stage drains).
- Packet end: an accepted flit with req_last, or flit_cnt reaching MAX_PKT_FLITS.
  - State -> IDLE.
  - rr_ptr <= (owner+1) mod NUM_REQ.
  - pkt_count increments.
  - On a forced end without last: len_err pulses for one cycle, and any remaining flits from that requester arbitrate as a new packet.
- rr_ptr changes only at packet end.
- Non-owner requesters always see req_ready=0 while LOCKED.

## Timing
- Reset values: out_valid=0, out_data=0, out_dest_x/y=0, req_ready=0, busy=0, owner=0, len_err=0, pkt_count=0, rr_ptr=0, flit_cnt=0, state=IDLE.
- Latency: a flit accepted in cycle N appears on out_* in cycle N+1. Full throughput is 1 flit/cycle while out_ready=1.
- Handshakes are valid/ready: a transfer occurs only when both are high. Held out_* must stay stable while out_valid & !out_ready.
- Back-to-back packets: the cycle after a packet end may arbitrate and accept the next head flit. There is no dead cycle.
- busy=1 from the cycle after a non-last head flit is accepted until the cycle after the packet end.
- Simultaneous events: a packet end and a new arbitration never occur in the same cycle. At most one flit is accepted per cycle.
- Reset mid-packet clears the lock and the output stage immediately. A partially sent packet is abandoned, and requesters must restart it.

## Structure
- The shared package noc_pkg holds:
  - the port index constants (NORTH=0, SOUTH=1, EAST=2, WEST=3, LOCAL=4);
  - the FLIT_WIDTH = DATA_WIDTH + 2*COORD_BITS rule and flit packing order {dest_y, dest_x, data};
  - the arbiter state encoding.
- One sub-module: rr_arbiter (parameter N; inputs req[N], ptr; outputs one-hot grant and index). It is purely combinational and reused by the router.

## Test plan
- Single requester, 3-flit packet (dest 2,1; last on 3rd), out_ready=1 -> out_* shows 3 flits on consecutive cycles one cycle late, all with dest (2,1); pkt_count=1; busy high 2 cycles.
- Requesters 0 and 2 both valid with 2-flit packets -> packets are not interleaved: r0 flits, then r2 flits; rr_ptr ends at 3; owner=2.
- out_ready toggles 1,0,0,1 mid-packet -> out_data held stable while stalled, no flit lost or duplicated, req_ready[owner] low during the stall.
- Owner r1 streams 17 flits with no last, MAX_PKT_FLITS=16 -> len_err pulses on the 16th acceptance; the 17th flit is sent as a new single-flit packet after re-arbitration; pkt_count=2.
- Head flit dest (5,5), body flits driving dest (0,0) -> all out_dest = (5,5).
- rst_n asserted mid-packet (after flit 2 of 4) -> all outputs are at reset values immediately; after release, r3's fresh packet wins with rr_ptr=0 search order.
